// File: rtl/uart_echo_bridge_if.sv
// Receive/transmit/status signal bundle for uart_echo_bridge.
// The bridge connects through the slave modport; the driving side
// (top level or testbench) connects through the master modport.
interface uart_echo_bridge_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [1:0]        mode;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              clr_stat;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
    logic              tx_err;

    modport slave (
        input  rx_data, rx_valid, mode, tx_busy, clr_stat,
        output rx_ready, tx_data, tx_start, fifo_count, overflow, drop_cnt, tx_err
    );

    modport master (
        output rx_data, rx_valid, mode, tx_busy, clr_stat,
        input  rx_ready, tx_data, tx_start, fifo_count, overflow, drop_cnt, tx_err
    );
endinterface

// File: rtl/uart_echo_bridge.sv
// Buffered UART echo bridge: received words go into a FIFO, are optionally
// transformed when popped (raw / uppercase / invert / LF->CR+LF) and are
// re-sent through a start/busy transmitter handshake guarded by a watchdog.
module uart_echo_bridge #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int BUSY_TO = 16,
    parameter int CNT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    uart_echo_bridge_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CW      = PTR_W + 1;
    localparam int WD_W    = $clog2(BUSY_TO);
    localparam bit IS_BYTE = (DATA_W == 8);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO} state_t;

    // Per-mode word transform; character modes only make sense for bytes.
    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] w,
                                                input logic [1:0] m);
        logic [DATA_W-1:0] r;
        r = w;
        case (m)
            2'b01: if (IS_BYTE && w >= DATA_W'(8'h61) && w <= DATA_W'(8'h7A))
                       r = w - DATA_W'(8'h20);
            2'b10: r = ~w;
            default: r = w;
        endcase
        return r;
    endfunction

    // Saturating increment for the drop counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d, tx_err_q, tx_err_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    state_t            state_q;
    logic [WD_W-1:0]   wdog_q;
    logic              pend_lf_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_start_q;

    logic              full, empty, push, drop, pop, wd_expire, pop_is_lf;
    logic [DATA_W-1:0] pop_word;

    // FIFO bookkeeping, pop decision, watchdog expiry and sticky statistics.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        push      = bus.rx_valid && !full;
        drop      = bus.rx_valid && full;
        pop       = (state_q == S_IDLE) && !pend_lf_q && !empty && !bus.tx_busy;
        wd_expire = (state_q == S_WAIT_HI) && !bus.tx_busy &&
                    (wdog_q == WD_W'(BUSY_TO - 1));
        pop_word  = mem_q[rptr_q];
        pop_is_lf = IS_BYTE && (bus.mode == 2'b11) && (pop_word == DATA_W'(8'h0A));

        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        tx_err_d   = tx_err_q;
        if (bus.clr_stat) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            tx_err_d   = 1'b0;
        end
        // A drop or expiry in the same cycle as a clear still gets recorded.
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = bus.clr_stat ? CNT_W'(1) : sat_inc(drop_cnt_q);
        end
        if (wd_expire)
            tx_err_d = 1'b1;
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= bus.rx_data;
    end

    // Pointer, occupancy and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            tx_err_q   <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            tx_err_q   <= tx_err_d;
        end
    end

    // Transmit FSM with registered start pulse and held transmit word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wdog_q     <= '0;
            pend_lf_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pend_lf_q) begin
                        tx_data_q  <= DATA_W'(8'h0A);
                        pend_lf_q  <= 1'b0;
                        tx_start_q <= 1'b1;
                        state_q    <= S_START;
                    end else if (pop) begin
                        tx_data_q  <= pop_is_lf ? DATA_W'(8'h0D) : xform(pop_word, bus.mode);
                        pend_lf_q  <= pop_is_lf;
                        tx_start_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    wdog_q  <= '0;
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.tx_busy) begin
                        state_q <= S_WAIT_LO;
                    end else if (wd_expire) begin
                        pend_lf_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.tx_busy)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready   = !full;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.tx_err     = tx_err_q;
endmodule

// File: tb/tb_uart_echo_bridge.sv
// Testbench for uart_echo_bridge: directed scenarios, a queue-based
// behavioural model checked every cycle, and literal expectations per scenario.
module tb_uart_echo_bridge;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int BUSY_TO = 16;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_echo_bridge_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    uart_echo_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BUSY_TO(BUSY_TO), .CNT_W(CNT_W))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int nprint = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (nprint < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            nprint++;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q [$];
    logic [7:0] sent [$];
    bit         m_lf, m_wait, m_ovf, m_err;
    int         m_wc, m_drop;

    logic       e_rst, e_valid, e_busy, e_clr;
    logic [7:0] e_data;
    logic [1:0] e_mode;

    function automatic logic [7:0] model_xf(input logic [7:0] w, input logic [1:0] m);
        if (m == 2'd1 && w >= "a" && w <= "z") return w - ("a" - "A");
        if (m == 2'd2) return ~w;
        return w;
    endfunction

    // Inputs are driven 2 time units after the rising edge, so they are stable here.
    always @(posedge clk) begin
        e_rst   = rst;
        e_valid = bus.rx_valid;
        e_data  = bus.rx_data;
        e_mode  = bus.mode;
        e_busy  = bus.tx_busy;
        e_clr   = bus.clr_stat;
    end

    always @(negedge clk) begin
        int pre;
        bit drop, expire;
        logic [7:0] w, exp_w;
        if (rst || e_rst) begin
            m_q.delete();
            m_lf = 0; m_wait = 0; m_ovf = 0; m_err = 0; m_drop = 0; m_wc = 0;
            chk("rst_tx_start", bus.tx_start, 0);
            chk("rst_tx_data", bus.tx_data, 0);
            chk("rst_fifo_count", bus.fifo_count, 0);
            chk("rst_overflow", bus.overflow, 0);
            chk("rst_drop_cnt", bus.drop_cnt, 0);
            chk("rst_tx_err", bus.tx_err, 0);
            chk("rst_rx_ready", bus.rx_ready, 1);
        end else begin
            pre = m_q.size();
            drop = 0;
            expire = 0;
            // busy-rise watchdog of the transfer in flight
            if (m_wait) begin
                if (m_wc < 0) m_wc = 0;
                else if (e_busy) m_wait = 0;
                else begin
                    m_wc++;
                    if (m_wc == BUSY_TO) begin
                        expire = 1; m_wait = 0; m_lf = 0;
                    end
                end
            end
            if (bus.tx_start) begin
                sent.push_back(bus.tx_data);
                chk("start_spacing", m_wait, 0);
                exp_w = 8'h00;
                if (m_lf) begin
                    exp_w = 8'h0A;
                    m_lf = 0;
                    chk("tx_data_lf", bus.tx_data, exp_w);
                end else if (pre == 0) begin
                    chk("start_without_word", bus.tx_start, 0);
                end else begin
                    w = m_q.pop_front();
                    if (e_mode == 2'd3 && w == 8'h0A) begin
                        exp_w = 8'h0D;
                        m_lf = 1;
                    end else begin
                        exp_w = model_xf(w, e_mode);
                    end
                    chk("tx_data", bus.tx_data, exp_w);
                end
                m_wait = 1;
                m_wc = -1;
            end
            if (e_valid) begin
                if (pre < DEPTH) m_q.push_back(e_data);
                else drop = 1;
            end
            if (e_clr) begin m_ovf = 0; m_err = 0; m_drop = 0; end
            if (drop) begin
                m_ovf = 1;
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
            if (expire) m_err = 1;
            chk("fifo_count", bus.fifo_count, m_q.size());
            chk("rx_ready", bus.rx_ready, (m_q.size() < DEPTH));
            chk("overflow", bus.overflow, m_ovf);
            chk("drop_cnt", bus.drop_cnt, m_drop);
            chk("tx_err", bus.tx_err, m_err);
        end
    end

    // ---------------- transmitter model ----------------
    // 0: busy rises one cycle after start, lasts 10 cycles; 1: stuck high; 2: stuck low
    int tx_mode = 0;
    initial begin
        int bcnt;
        bcnt = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (tx_mode)
                1: bus.tx_busy = 1'b1;
                2: bus.tx_busy = 1'b0;
                default: begin
                    bus.tx_busy = (bcnt > 0);
                    if (bcnt > 0) bcnt--;
                    if (bus.tx_start) bcnt = 10;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] w);
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        cyc(1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic chk_sent(input string name, input int idx, input logic [7:0] exp);
        chk(name, (idx < sent.size()) ? {24'h0, sent[idx]} : 32'hFFFF_FFFF, {24'h0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.mode     = 2'b00;
        bus.clr_stat = 1'b0;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // T1: single raw word, latency and data
        sent.delete();
        push(8'h41);
        @(negedge clk);
        chk("t1_count_after_push", bus.fifo_count, 1);
        chk("t1_no_early_start", bus.tx_start, 0);
        @(negedge clk);
        chk("t1_start", bus.tx_start, 1);
        chk("t1_data", bus.tx_data, 8'h41);
        chk("t1_count_after_pop", bus.fifo_count, 0);
        cyc(30);
        chk("t1_sent_n", sent.size(), 1);
        chk_sent("t1_sent0", 0, 8'h41);

        // T2: uppercase mode
        bus.mode = 2'b01;
        sent.delete();
        push(8'h61); push(8'h7A); push(8'h7B); push(8'h5A);
        cyc(100);
        chk("t2_sent_n", sent.size(), 4);
        chk_sent("t2_sent0", 0, 8'h41);
        chk_sent("t2_sent1", 1, 8'h5A);
        chk_sent("t2_sent2", 2, 8'h7B);
        chk_sent("t2_sent3", 3, 8'h5A);

        // T2b: invert mode
        bus.mode = 2'b10;
        sent.delete();
        push(8'h3C);
        cyc(30);
        chk_sent("t2b_invert", 0, 8'hC3);

        // T3: LF expansion
        bus.mode = 2'b11;
        sent.delete();
        push(8'h0A); push(8'h42);
        cyc(80);
        chk("t3_sent_n", sent.size(), 3);
        chk_sent("t3_sent0", 0, 8'h0D);
        chk_sent("t3_sent1", 1, 8'h0A);
        chk_sent("t3_sent2", 2, 8'h42);
        chk("t3_count", bus.fifo_count, 0);

        // T4: overflow with transmitter held busy
        bus.mode = 2'b00;
        tx_mode = 1;
        cyc(2);
        sent.delete();
        for (int i = 0; i < DEPTH + 3; i++) push(8'h30 + 8'(i));
        cyc(2);
        chk("t4_count_full", bus.fifo_count, DEPTH);
        chk("t4_rx_ready", bus.rx_ready, 0);
        chk("t4_overflow", bus.overflow, 1);
        chk("t4_drop_cnt", bus.drop_cnt, 3);
        chk("t4_nothing_sent", sent.size(), 0);
        bus.clr_stat = 1'b1;
        cyc(1);
        bus.clr_stat = 1'b0;
        chk("t4_overflow_clr", bus.overflow, 0);
        chk("t4_drop_clr", bus.drop_cnt, 0);
        tx_mode = 0;
        cyc(300);
        chk("t4_drain_n", sent.size(), DEPTH);
        chk_sent("t4_first", 0, 8'h30);
        chk_sent("t4_last", DEPTH - 1, 8'h3F);
        chk("t4_count_empty", bus.fifo_count, 0);

        // T5: watchdog with busy stuck low
        tx_mode = 2;
        cyc(2);
        sent.delete();
        push(8'h55); push(8'h66);
        cyc(5);
        chk("t5_err_not_yet", bus.tx_err, 0);
        chk("t5_one_start", sent.size(), 1);
        cyc(50);
        chk("t5_err", bus.tx_err, 1);
        chk("t5_sent_n", sent.size(), 2);
        chk_sent("t5_sent0", 0, 8'h55);
        chk_sent("t5_sent1", 1, 8'h66);
        bus.clr_stat = 1'b1;
        cyc(1);
        bus.clr_stat = 1'b0;
        chk("t5_err_clr", bus.tx_err, 0);

        // T6: reset during WAIT_LO with words queued
        tx_mode = 0;
        cyc(2);
        sent.delete();
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.tx_busy) seen = 1;
            else cyc(1);
        end
        chk("t6_busy_seen", seen, 1);
        cyc(3);
        chk("t6_queued", bus.fifo_count, 4);
        rst = 1'b1;
        #1;
        chk("t6_async_count", bus.fifo_count, 0);
        chk("t6_async_ready", bus.rx_ready, 1);
        cyc(2);
        rst = 1'b0;
        cyc(30);
        chk("t6_no_start_after_rst", sent.size(), 1);
        push(8'h77);
        cyc(40);
        chk("t6_new_n", sent.size(), 2);
        chk_sent("t6_new_word", 1, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
